regfile_bank: RTL and testbench

Parametrised multi-read, dual-write integer register file for the RISC-V core. It succeeds the fixed 32×32, 2-read/1-write register file. It adds a configurable read-port count, a second write port for load/ALU writeback, and a hardware clearing sequencer that zeroes every register after reset. It sits between decode (read addresses) and writeback (write ports), with `busy` stalling the pipeline until the clear completes.

---
 rtl/regfile_bank_if.sv | 29 ++
 rtl/regfile_bank.sv | 89 ++++++++
 tb/tb_regfile_bank.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_bank_if.sv
// Register-file access bundle: two write ports plus NRP packed read ports and the busy flag.
// Latency: none (wires only).
// Backpressure: none; writers and readers must observe busy themselves.
interface regfile_bank_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
);
    logic                decode_we0;
    logic                we0;
    logic [AW-1:0]       wa0;
    logic [XLEN-1:0]     wd0;
    logic                we1;
    logic [AW-1:0]       wa1;
    logic [XLEN-1:0]     wd1;
    logic [NRP*AW-1:0]   ra;
    logic [NRP*XLEN-1:0] rd;
    logic                busy;

    modport master (
        output we0, wa0, wd0, we1, wa1, wd1, ra,
        input  rd, busy
    );

    modport slave (
        input  we0, wa0, wd0, we1, wa1, wd1, ra,
        output rd, busy
    );
endinterface

// File: rtl/regfile_bank.sv
// Integer register file: NRP combinational read ports, 2 write ports, post-reset hardware zeroing sweep.
// Latency: writes visible one edge later (zero with RF_BYPASS_EN defined); clear takes NREG-1 edges.
// Backpressure: busy is high during the sweep; writes are dropped and reads return 0 until it falls.
module regfile_bank #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
) (
    input logic          clk,
    input logic          rst,
    regfile_bank_if.slave bus
);
    localparam int NREG = 1 << AW;

    typedef enum logic {CLEAR, RUN} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    // x0 is hardwired to zero, so no storage exists for it
    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];
    logic            busy;

    assign busy     = (state_q == CLEAR);
    assign bus.busy = busy;

    // Next state: in CLEAR zero one register per edge, in RUN commit writes (port 1 applied last so it wins)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        if (state_q == CLEAR) begin
            if (cnt_q != '0) begin
                regs_d[cnt_q] = '0;
            end
            if (cnt_q == {AW{1'b1}}) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (bus.we0 && (bus.wa0 != '0)) begin
                regs_d[bus.wa0] = bus.wd0;
            end
            if (bus.we1 && (bus.wa1 != '0)) begin
                regs_d[bus.wa1] = bus.wd1;
            end
        end
    end

    // State update; reset restarts the sweep but leaves register contents (and any write) untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= {{(AW-1){1'b0}}, 1'b1};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
        end
    end

    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = bus.ra[i*AW +: AW];

        // Read mux: x0 and the clear sweep force zero; optional forwarding from same-cycle writes
        always_comb begin
            data = '0;
            if (!busy && (addr != '0)) begin
`ifdef RF_BYPASS_EN
                if (bus.we1 && (bus.wa1 == addr)) begin
                    data = bus.wd1;
                end else if (bus.we0 && (bus.wa0 == addr)) begin
                    data = bus.wd0;
                end else begin
                    data = regs_q[addr];
                end
`else
                data = regs_q[addr];
`endif
            end
        end

        assign bus.rd[i*XLEN +: XLEN] = data;
    end
endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank against a behavioural register-file model.
// Latency: model applies writes at each rising edge; reads compared combinationally before the edge.
// Backpressure: model tracks the clear sweep as a countdown of busy cycles.
module tb_regfile_bank;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRP  = 2;
    localparam int NREG = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    regfile_bank_if #(.XLEN(XLEN), .AW(AW), .NRP(NRP)) rf_if ();

    regfile_bank #(.XLEN(XLEN), .AW(AW), .NRP(NRP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if)
    );

    logic [XLEN-1:0] mem [NREG];
    bit              m_busy;
    int              m_left;
    int              checks = 0;
    int              errors = 0;
`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] rd_port(input int p);
        return rf_if.rd[p*XLEN +: XLEN];
    endfunction

    function automatic logic [AW-1:0] ra_port(input int p);
        return rf_if.ra[p*AW +: AW];
    endfunction

    // Expected read value from the architectural model
    function automatic logic [XLEN-1:0] exp_rd(input int p);
        logic [AW-1:0] a;
        a = ra_port(p);
        if (m_busy || a == 0) return '0;
        if (BYPASS && rf_if.we1 && rf_if.wa1 == a) return rf_if.wd1;
        if (BYPASS && rf_if.we0 && rf_if.wa0 == a) return rf_if.wd0;
        return mem[a];
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_busy"}, {{(XLEN-1){1'b0}}, rf_if.busy}, {{(XLEN-1){1'b0}}, m_busy});
        for (int p = 0; p < NRP; p++) begin
            chk($sformatf("%s_rd%0d", tag, p), rd_port(p), exp_rd(p));
        end
    endtask

    // Model of one rising edge, using the inputs held across it
    task automatic model_edge();
        if (rst) begin
            m_busy = 1'b1;
            m_left = NREG - 1;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                for (int r = 0; r < NREG; r++) mem[r] = '0;
            end
        end else begin
            if (rf_if.we0 && rf_if.wa0 != 0) mem[rf_if.wa0] = rf_if.wd0;
            if (rf_if.we1 && rf_if.wa1 != 0) mem[rf_if.wa1] = rf_if.wd1;
        end
    endtask

    task automatic cycle(input string tag);
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_wr(input logic e0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                          input logic e1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
        rf_if.we0 = e0; rf_if.wa0 = a0; rf_if.wd0 = d0;
        rf_if.we1 = e1; rf_if.wa1 = a1; rf_if.wd1 = d1;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        logic [NRP*AW-1:0] v;
        v = '0;
        v[0 +: AW]  = a0;
        v[AW +: AW] = a1;
        rf_if.ra = v;
    endtask

    task automatic rand_inputs(input bit same_addr_bias);
        logic [AW-1:0] a0, a1;
        a0 = AW'($urandom_range(0, NREG-1));
        a1 = (same_addr_bias && $urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, NREG-1));
        set_wr(1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom);
        set_ra(($urandom_range(0, 2) == 0) ? a0 : AW'($urandom_range(0, NREG-1)),
               ($urandom_range(0, 2) == 0) ? a1 : AW'($urandom_range(0, NREG-1)));
    endtask

    // Run the sweep with random (ignored) traffic; report how many busy cycles were seen
    task automatic run_clear(input string tag);
        int n;
        n = 0;
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (!rf_if.busy) break;
            n++;
            rand_inputs(1'b0);
            cycle(tag);
        end
        chk({tag, "_len"}, XLEN'(n), XLEN'(NREG - 1));
        set_wr(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_busy = 1'b1;
        m_left = NREG - 1;
        for (int r = 0; r < NREG; r++) mem[r] = '0;
        set_wr(0, 0, 0, 0, 0, 0);
        set_ra(0, 0);

        // Power-up reset: reset edge then check state after it
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("reset");
        run_clear("clear0");

        // Preload x7, pulse reset, x7 must come back zero
        set_wr(1, 7, 32'hDEADBEEF, 0, 0, 0);
        set_ra(7, 7);
        cycle("preload");
        set_wr(0, 0, 0, 0, 0, 0);
        #1;
        chk("x7_preload", rd_port(0), 32'hDEADBEEF);
        rst = 1'b1;
        cycle("rst_pulse");
        run_clear("clear1");
        set_ra(7, 7);
        #1;
        chk("x7_cleared", rd_port(0), 32'h0);

        // Basic write/read on both ports
        set_wr(1, 5, 32'h0000000A, 0, 0, 0);
        cycle("wr_x5");
        set_wr(0, 0, 0, 1, 6, 32'h0000000B);
        cycle("wr_x6");
        set_wr(0, 0, 0, 0, 0, 0);
        set_ra(5, 6);
        #1;
        chk("basic_rd0", rd_port(0), 32'h0000000A);
        chk("basic_rd1", rd_port(1), 32'h0000000B);

        // Same-address conflict: port 1 wins
        set_wr(1, 9, 32'h11111111, 1, 9, 32'h22222222);
        cycle("conflict");
        set_wr(0, 0, 0, 0, 0, 0);
        set_ra(9, 9);
        #1;
        chk("conflict_x9", rd_port(0), 32'h22222222);

        // x0 protection
        set_wr(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF);
        set_ra(0, 0);
        cycle("x0_wr");
        set_wr(0, 0, 0, 0, 0, 0);
        #1;
        chk("x0_rd0", rd_port(0), 32'h0);
        chk("x0_rd1", rd_port(1), 32'h0);

        // Bypass behaviour on x3
        set_wr(1, 3, 32'h00000001, 0, 0, 0);
        cycle("x3_init");
        set_wr(1, 3, 32'h12345678, 0, 0, 0);
        set_ra(3, 0);
        #1;
        chk("bypass_same", rd_port(0), BYPASS ? 32'h12345678 : 32'h00000001);
        cycle("x3_wr");
        set_wr(0, 0, 0, 0, 0, 0);
        #1;
        chk("bypass_next", rd_port(0), 32'h12345678);

        // Reset at clear cycle 10 restarts the full sweep
        rst = 1'b1;
        cycle("rst_a");
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rand_inputs(1'b0);
            cycle("clear_part");
        end
        rst = 1'b1;
        cycle("rst_mid");
        run_clear("clear2");

        // Reset in RUN drops the write presented on the same edge
        set_wr(1, 4, 32'h00000055, 0, 0, 0);
        cycle("x4_pre");
        set_wr(1, 4, 32'h000000AA, 0, 0, 0);
        rst = 1'b1;
        cycle("rst_run");
        run_clear("clear3");
        set_ra(4, 4);
        #1;
        chk("x4_dropped", rd_port(0), 32'h0);

        // Random traffic against the model, with an occasional reset
        for (int k = 0; k < 400; k++) begin
            rand_inputs(1'b1);
            rst = ($urandom_range(0, 149) == 0);
            cycle("rand");
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
